// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding, timing constants and payload widths
// for the APB request arbiter.
package apb_arb_pkg;
   localparam int HOLD_CYC = 4;
   localparam int GAP_CYC = 2;
   localparam int AW = 8;
   localparam int DW = 16;
   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_GAP
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past last.
module rr_arbiter #(
   parameter int N = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = N; k >= 1; k--)
         if (req[(int'(last) + k) % N]) begin
            idx = IW'((int'(last) + k) % N);
            any = 1'b1;
         end
   end
   assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/apb_req_arb.sv
// apb_req_arb: round-robin sharing of the command-level APB config port.
// Define APB_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
module apb_req_arb
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                  apb_clk,
   input  logic                  apb_rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [AW*NUM_REQ-1:0] req_addr,
   input  logic [DW*NUM_REQ-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]    req_port,
   output logic [NUM_REQ-1:0]    ack,
   output logic [DW-1:0]         rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  apb_cmd_en,
   output logic                  apb_wr_en,
   output logic                  apb_port,
   output logic [AW-1:0]         apb_wr_addr,
   output logic [DW-1:0]         apb_wr_data,
   input  logic                  apb_done,
   input  logic [DW-1:0]         apb_rd_data
);
   localparam int IW = $clog2(NUM_REQ);
   state_t state;
   logic [IW-1:0] last_gnt, win, gidx;
   logic [NUM_REQ-1:0] gnt;
   logic [2:0] cnt;
   logic any, seen_low, done_ok, expired;
   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req(req),
      .last(last_gnt),
      .gnt(gnt),
      .idx(gidx),
      .any(any)
   );
   assign done_ok = seen_low && apb_done;
   assign busy = state != S_IDLE;
   assign apb_cmd_en = state == S_ISSUE;
`ifdef APB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer;
   assign expired = state == S_WAIT && timer == TW'(TIMEOUT - 1);
   always_ff @(posedge apb_clk)
      if (apb_rst || state != S_WAIT) timer <= '0;
      else timer <= timer + 1'b1;
`else
   // A negative TIMEOUT is meaningless, so this folds to a constant 0.
   assign expired = TIMEOUT < 0;
`endif
   always_ff @(posedge apb_clk) begin
      if (apb_rst) begin
         state <= S_IDLE;
         last_gnt <= IW'(NUM_REQ - 1);
         win <= '0;
         cnt <= '0;
         seen_low <= 1'b0;
         ack <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         apb_wr_en <= 1'b0;
         apb_port <= 1'b0;
         apb_wr_addr <= '0;
         apb_wr_data <= '0;
      end else begin
         ack <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         case (state)
            S_IDLE:
               if (any) begin
                  state <= S_ISSUE;
                  win <= gidx;
                  last_gnt <= gidx;
                  cnt <= '0;
                  seen_low <= 1'b0;
                  apb_wr_en <= req_wr[gidx];
                  apb_port <= req_port[gidx];
                  apb_wr_addr <= req_addr[gidx*AW +: AW];
                  apb_wr_data <= req_wdata[gidx*DW +: DW];
               end
            S_ISSUE: begin
               seen_low <= seen_low | ~apb_done;
               cnt <= cnt + 1'b1;
               if (cnt == 3'(HOLD_CYC - 1)) state <= S_WAIT;
            end
            S_WAIT: begin
               seen_low <= seen_low | ~apb_done;
               if (done_ok || expired) begin
                  state <= S_RESP;
                  ack <= NUM_REQ'(1) << win;
                  rsp_rdata <= done_ok && !apb_wr_en ? apb_rd_data : '0;
                  rsp_err <= !done_ok;
               end
            end
            S_RESP: begin
               state <= S_GAP;
               cnt <= '0;
            end
            S_GAP: begin
               cnt <= cnt + 1'b1;
               if (cnt == 3'(GAP_CYC - 1)) begin
                  state <= S_IDLE;
                  apb_wr_en <= 1'b0;
                  apb_port <= 1'b0;
                  apb_wr_addr <= '0;
                  apb_wr_data <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/apb_req_arb.md
# apb_req_arb

Round-robin arbiter and sequencer that shares the single command-level APB configuration port of the DDR3 example design among several requesters (init FSM, calibration monitor, debug UART bridge). It accepts per-requester read/write requests, converts the granted one into the level-held command protocol the APB controller expects, and returns read data or a timeout error to the winner.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 1023, max cycles waiting for completion before error

Ports:
- apb_clk  in  1  clock
- apb_rst  in  1  reset; **one clock; reset is synchronous and active-high**
- req  in  NUM_REQ  request level per requester; held until ack
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  8*NUM_REQ  register address, slice i for requester i
- req_wdata  in  16*NUM_REQ  write data, slice i
- req_port  in  NUM_REQ  target APB port (0/1)
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- rsp_rdata  out  16  read data, valid with ack
- rsp_err  out  1  timeout flag, valid with ack
- busy  out  1  high from grant until return to IDLE
- apb_cmd_en  out  1  command strobe to controller (level, rising edge = command)
- apb_wr_en, apb_port  out  1  command type / port, stable while cmd_en high and during WAIT
- apb_wr_addr  out  8; apb_wr_data  out  16  command payload, same stability rule
- apb_done  in  1  controller done level: falls on command accept, rises on completion
- apb_rd_data  in  16  controller read data, valid when apb_done high

## Operation
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE: if any req, pick winner starting at (last_gnt+1) mod NUM_REQ; register its wr/addr/wdata/port onto apb_* outputs, update last_gnt, go ISSUE. last_gnt resets to NUM_REQ-1 (requester 0 wins first).
- ISSUE: apb_cmd_en=1 for exactly HOLD_CYC=4 cycles, then WAIT.
- WAIT: apb_cmd_en=0; flag seen_low sets when apb_done==0 (sampling starts in ISSUE). Completion = seen_low && apb_done==1 → RESP.
- RESP: ack[winner]=1 one cycle; rsp_rdata = apb_rd_data for reads, 0 for writes; rsp_err=0. Go GAP.
- GAP: cmd_en low GAP_CYC=2 cycles, then IDLE.
- Requester dropping req mid-transaction: transaction completes, ack still pulsed; no abort.
- New requests during busy are only sampled in IDLE; back-to-back requester is re-eligible, but rotation guarantees others win first.
- Payload outputs hold from grant to end of GAP; cleared to 0 in IDLE.

## Timing
- Reset: state IDLE; ack, rsp_rdata, rsp_err, busy, apb_cmd_en, apb_wr_en, apb_port, apb_wr_addr, apb_wr_data all 0; seen_low 0; timer 0.
- Reset mid-transaction: immediate return to IDLE, no ack; cmd_en drops next cycle.
- Grant latency: req high in cycle t → apb_cmd_en high from t+1 to t+4, busy high from t+1.
- ack one cycle after the cycle completion is detected; ack to next possible cmd_en rise: ≥3 cycles.
- Simultaneous req from all: served 0,1,2,3,0… one per transaction.

## Configuration
- APB_ARB_TIMEOUT_EN defined: timer counts cycles in WAIT; reaching TIMEOUT → RESP with rsp_err=1, rsp_rdata=0, then normal GAP.
- Undefined: no timer logic; WAIT waits indefinitely; rsp_err tied 0.

## Structure
- Package apb_arb_pkg: state encoding enum, HOLD_CYC, GAP_CYC, address/data width constants.
- Sub-module rr_arbiter: combinational round-robin pick (req vector + last_gnt → one-hot grant + index); top holds FSM, payload mux and timer.

## Test plan
- Single write: req[0], addr 0x12, wdata 0xA5A5, controller model accepts → one cmd_en pulse of 4 cycles, apb_wr_addr=0x12, ack[0] once, rsp_err=0.
- Read on port 1: req[2], req_port=1, model returns 0x3C5A → rsp_rdata=0x3C5A with ack[2].
- Contention: req=4'b1111 held continuously → ack order 0,1,2,3,0; no two acks in the same transaction.
- Timeout (macro on, TIMEOUT=16): model never raises done → ack with rsp_err=1, rsp_rdata=0 after 16 WAIT cycles; next request served normally.
- Reset during WAIT: apb_rst one cycle → all outputs 0 next cycle, no ack; following req[1] granted first (last_gnt reset).
- Req dropped after grant: req[3] deasserted in ISSUE → transaction completes, ack[3] pulsed, no re-issue.
